// File: rtl/wb_dbus_interconnect_pkg.sv
// wb_dbus_interconnect_pkg: FSM states and the default Hydrogen data-bus address map
package wb_dbus_interconnect_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, UNMAP} state_t;

    // Slots from 0 upward: RAM, UART, GPIO0, GPIO1
    localparam logic [127:0] DEF_SLV_BASE = {32'h0800_0104, 32'h0800_0100, 32'h0800_0000, 32'h0400_0000};
    localparam logic [127:0] DEF_SLV_MASK = {32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hFC00_0000};

endpackage

// File: rtl/wb_dbus_interconnect_if.sv
// wb_dbus_interconnect_if: master-side and slave-side Wishbone signals routed by the interconnect
interface wb_dbus_interconnect_if #(parameter int NUM_SLV = 4);

    logic [31:0]          m_adr_i;
    logic                 m_cyc_i;
    logic                 m_stb_i;
    logic [31:0]          m_dat_o;
    logic                 m_ack_o;
    logic [NUM_SLV-1:0]   s_stb_o;
    logic [NUM_SLV-1:0]   s_ack_i;
    logic [NUM_SLV*32-1:0] s_dat_i;

    // Interconnect view
    modport slave (
        input  m_adr_i, m_cyc_i, m_stb_i, s_ack_i, s_dat_i,
        output m_dat_o, m_ack_o, s_stb_o
    );

    // Environment view: core master plus the slave devices
    modport master (
        output m_adr_i, m_cyc_i, m_stb_i, s_ack_i, s_dat_i,
        input  m_dat_o, m_ack_o, s_stb_o
    );

endinterface

// File: rtl/wb_dbus_interconnect_decoder.sv
// wb_dbus_interconnect_decoder: base/mask address match with lowest-index priority
module wb_dbus_interconnect_decoder
    import wb_dbus_interconnect_pkg::*;
#(
    parameter int                   NUM_SLV = 4,
    parameter logic [NUM_SLV*32-1:0] BASE   = DEF_SLV_BASE,
    parameter logic [NUM_SLV*32-1:0] MASK   = DEF_SLV_MASK
) (
    input  logic [31:0] adr_i,
    output logic        hit_o,
    output logic [2:0]  idx_o
);

    // Scan from the top slot down so the lowest matching index is what remains
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((adr_i & MASK[32*i+:32]) == BASE[32*i+:32]) begin
                hit_o = 1'b1;
                idx_o = 3'(i);
            end
        end
    end

endmodule

// File: rtl/wb_dbus_interconnect.sv
// wb_dbus_interconnect: registered-decode Wishbone classic interconnect with timeout and error capture
module wb_dbus_interconnect
    import wb_dbus_interconnect_pkg::*;
#(
    parameter int                   NUM_SLV     = 4,
    parameter logic [NUM_SLV*32-1:0] SLV_BASE    = DEF_SLV_BASE,
    parameter logic [NUM_SLV*32-1:0] SLV_MASK    = DEF_SLV_MASK,
    parameter int                   TIMEOUT_CYC = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    wb_dbus_interconnect_if.slave  bus,
    input  logic                   err_clr_i,
    output logic                   err_valid_o,
    output logic                   err_timeout_o,
    output logic [31:0]            err_adr_o,
    output logic [2:0]             cur_slv_o
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    state_t             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               err_valid_q, err_timeout_q;
    logic [31:0]        err_adr_q;
    logic               hit;
    logic [2:0]         idx;
    logic [NUM_SLV-1:0] sel_oh;
    logic               ack_sel;
    logic [31:0]        dat_sel;
    logic               cap, cap_to;

    wb_dbus_interconnect_decoder #(
        .NUM_SLV (NUM_SLV),
        .BASE    (SLV_BASE),
        .MASK    (SLV_MASK)
    ) u_dec (
        .adr_i (bus.m_adr_i),
        .hit_o (hit),
        .idx_o (idx)
    );

    // Select the latched slave's ack and read data
    always_comb begin
        sel_oh  = NUM_SLV'(1) << sel_q;
        ack_sel = |(bus.s_ack_i & sel_oh);
        dat_sel = '0;
        for (int i = 0; i < NUM_SLV; i++)
            if (sel_q == 3'(i)) dat_sel = bus.s_dat_i[32*i+:32];
    end

    // Next state and bus outputs; abort beats ack, ack beats timeout
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        bus.s_stb_o = '0;
        bus.m_ack_o = 1'b0;
        bus.m_dat_o = '0;
        cap         = 1'b0;
        cap_to      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.m_cyc_i && bus.m_stb_i) begin
                    state_d = hit ? BUSY : UNMAP;
                    sel_d   = hit ? idx : sel_q;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (!bus.m_cyc_i) begin
                    state_d = IDLE;
                end else if (ack_sel) begin
                    bus.s_stb_o = bus.m_stb_i ? sel_oh : '0;
                    bus.m_ack_o = 1'b1;
                    bus.m_dat_o = dat_sel;
                    state_d     = IDLE;
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    bus.m_ack_o = 1'b1;
                    cap         = 1'b1;
                    cap_to      = 1'b1;
                    state_d     = IDLE;
                end else begin
                    bus.s_stb_o = bus.m_stb_i ? sel_oh : '0;
                    cnt_d       = cnt_q + 1'b1;
                end
            end
            UNMAP: begin
                bus.m_ack_o = 1'b1;
                cap         = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched slave and timeout counter
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sticky error status: a new capture overrides a simultaneous clear
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            err_valid_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            err_adr_q     <= '0;
        end else if (cap) begin
            err_valid_q   <= 1'b1;
            err_timeout_q <= cap_to;
            err_adr_q     <= bus.m_adr_i;
        end else if (err_clr_i) begin
            err_valid_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            err_adr_q     <= '0;
        end
    end

    assign err_valid_o   = err_valid_q;
    assign err_timeout_o = err_timeout_q;
    assign err_adr_o     = err_adr_q;
    assign cur_slv_o     = sel_q;

endmodule

// File: tb/tb_wb_dbus_interconnect.sv
// tb_wb_dbus_interconnect: directed stimulus with a queue-based scoreboard for acks and strobes
module tb_wb_dbus_interconnect;

    localparam int NS = 4;

    typedef struct {
        logic [31:0]   dat;
        logic [NS-1:0] stb;
        int            cyc;
    } ack_t;

    typedef struct {
        logic [NS-1:0] stb;
        logic [2:0]    idx;
        int            cyc;
    } stb_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          err_clr = 1'b0;
    logic          err_valid, err_to;
    logic [31:0]   err_adr;
    logic [2:0]    cur_slv;
    logic [NS-1:0] ack_r = '0;
    logic [NS-1:0] xack = '0;
    logic [NS-1:0] prev_stb = '0;
    int            lat[NS];
    int            cnt[NS];
    int            cyc = 0;
    int            n_chk = 0;
    int            n_err = 0;
    int            k;
    ack_t          ack_exp[$];
    stb_t          stb_exp[$];
    ack_t          ea;
    stb_t          es;

    wb_dbus_interconnect_if #(.NUM_SLV(NS)) bus ();

    wb_dbus_interconnect #(
        .NUM_SLV     (NS),
        .TIMEOUT_CYC (4)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .bus           (bus.slave),
        .err_clr_i     (err_clr),
        .err_valid_o   (err_valid),
        .err_timeout_o (err_to),
        .err_adr_o     (err_adr),
        .cur_slv_o     (cur_slv)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign bus.s_dat_i = {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001, 32'h1234_5678};
    assign bus.s_ack_i = ack_r | xack;

    // Slave models: ack for one cycle after seeing strobe for lat cycles (lat 0 = never)
    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (ack_r[i]) begin
                ack_r[i] <= 1'b0;
                cnt[i]   <= 0;
            end else if (bus.s_stb_o[i]) begin
                cnt[i] <= cnt[i] + 1;
                if (lat[i] != 0 && cnt[i] + 1 == lat[i]) ack_r[i] <= 1'b1;
            end else begin
                cnt[i] <= 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop and compare whenever the DUT acks or raises a new strobe
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.m_ack_o) begin
                if (ack_exp.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL stray_ack: got ack dat=%h expected no ack (cycle %0d)", bus.m_dat_o, cyc);
                end else begin
                    ea = ack_exp.pop_front();
                    chk("ack_dat", bus.m_dat_o, ea.dat);
                    chk("ack_cycle", cyc, ea.cyc);
                    chk("ack_stb", 32'(bus.s_stb_o), 32'(ea.stb));
                end
            end else begin
                chk("dat_no_ack", bus.m_dat_o, 32'h0);
            end
            if (bus.s_stb_o != '0 && prev_stb == '0) begin
                if (stb_exp.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL stray_stb: got %b expected none (cycle %0d)", bus.s_stb_o, cyc);
                end else begin
                    es = stb_exp.pop_front();
                    chk("stb_pattern", 32'(bus.s_stb_o), 32'(es.stb));
                    chk("stb_cycle", cyc, es.cyc);
                    chk("cur_slv", 32'(cur_slv), 32'(es.idx));
                end
            end
        end
        prev_stb <= bus.s_stb_o;
    end

    task automatic start(input logic [31:0] a);
        bus.m_adr_i = a;
        bus.m_cyc_i = 1'b1;
        bus.m_stb_i = 1'b1;
    endtask

    task automatic idle();
        bus.m_cyc_i = 1'b0;
        bus.m_stb_i = 1'b0;
    endtask

    task automatic wait_ack();
        int n = 0;
        forever begin
            @(negedge clk);
            if (bus.m_ack_o) break;
            if (++n > 20) begin
                chk("ack_wait_timeout", 32'(n), 32'(0));
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        k = cyc;
    endtask

    initial begin
        for (int i = 0; i < NS; i++) begin
            lat[i] = 1;
            cnt[i] = 0;
        end
        bus.m_adr_i = '0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stb", 32'(bus.s_stb_o), 32'h0);
        chk("rst_ack", 32'(bus.m_ack_o), 32'h0);
        chk("rst_dat", bus.m_dat_o, 32'h0);
        chk("rst_err_valid", 32'(err_valid), 32'h0);
        chk("rst_err_adr", err_adr, 32'h0);
        chk("rst_cur_slv", 32'(cur_slv), 32'h0);
        rst = 1'b0;

        // RAM read, two-cycle slave latency
        lat[0] = 2;
        next();
        stb_exp.push_back('{4'b0001, 3'd0, k + 1});
        ack_exp.push_back('{32'h1234_5678, 4'b0001, k + 3});
        start(32'h0400_0010);
        wait_ack();
        chk("idle_after_ack_stb", 32'(bus.s_stb_o), 32'h0);
        idle();

        // Back-to-back UART then GPIO1
        next();
        stb_exp.push_back('{4'b0010, 3'd1, k + 1});
        ack_exp.push_back('{32'hAAAA_0001, 4'b0010, k + 2});
        start(32'h0800_0000);
        wait_ack();
        k = cyc;
        stb_exp.push_back('{4'b1000, 3'd3, k + 1});
        ack_exp.push_back('{32'hCCCC_0003, 4'b1000, k + 2});
        start(32'h0800_0104);
        wait_ack();
        idle();

        // Unmapped access
        next();
        ack_exp.push_back('{32'h0, 4'b0000, k + 1});
        start(32'h0C00_0000);
        wait_ack();
        idle();
        chk("unmap_err_valid", 32'(err_valid), 32'h1);
        chk("unmap_err_to", 32'(err_to), 32'h0);
        chk("unmap_err_adr", err_adr, 32'h0C00_0000);

        // Slave hang on GPIO0: forced completion on the 4th BUSY cycle
        lat[2] = 0;
        next();
        stb_exp.push_back('{4'b0100, 3'd2, k + 1});
        ack_exp.push_back('{32'h0, 4'b0000, k + 4});
        start(32'h0800_0100);
        wait_ack();
        idle();
        chk("to_err_valid", 32'(err_valid), 32'h1);
        chk("to_err_to", 32'(err_to), 32'h1);
        chk("to_err_adr", err_adr, 32'h0800_0100);
        xack[2] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        xack[2] = 1'b0;

        // Clear alone, then clear colliding with a new unmapped capture
        next();
        err_clr = 1'b1;
        next();
        err_clr = 1'b0;
        chk("clr_err_valid", 32'(err_valid), 32'h0);
        next();
        ack_exp.push_back('{32'h0, 4'b0000, k + 1});
        start(32'h2000_0000);
        next();
        err_clr = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        idle();
        chk("clr_vs_cap_valid", 32'(err_valid), 32'h1);
        chk("clr_vs_cap_adr", err_adr, 32'h2000_0000);

        // Asynchronous reset mid-BUSY
        lat[0] = 0;
        next();
        stb_exp.push_back('{4'b0001, 3'd0, k + 1});
        start(32'h0400_0020);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_stb", 32'(bus.s_stb_o), 32'h0);
        chk("arst_ack", 32'(bus.m_ack_o), 32'h0);
        chk("arst_err_valid", 32'(err_valid), 32'h0);
        chk("arst_err_to", 32'(err_to), 32'h0);
        chk("arst_err_adr", err_adr, 32'h0);
        chk("arst_cur_slv", 32'(cur_slv), 32'h0);
        idle();
        #3;
        rst = 1'b0;
        lat[0] = 2;
        next();
        stb_exp.push_back('{4'b0001, 3'd0, k + 1});
        ack_exp.push_back('{32'h1234_5678, 4'b0001, k + 3});
        start(32'h0400_0030);
        wait_ack();
        idle();

        repeat (3) @(posedge clk);
        #1;
        chk("ack_queue_drained", 32'(ack_exp.size()), 32'h0);
        chk("stb_queue_drained", 32'(stb_exp.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
